gpio_pattern_sequencer: RTL and testbench

GPIO_PATTERN_SEQUENCER -- requirements
Module: gpio_pattern_sequencer

---
 rtl/gpio_pattern_sequencer.sv | 177 +++++++++++++++++
 tb/tb_gpio_pattern_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_sequencer.sv
// GPIO pattern sequencer: a small config slave holds an 8-entry pattern table.
// On START the block replays TABLE[0..LENGTH] to a PIO slave through its
// master port, one write every PERIOD+1 cycles, once or in a loop.
module gpio_pattern_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            index_q, index_d;
  logic [15:0]           count_q, count_d;
  logic                  done_q, done_d;
  logic [15:0]           period_q;
  logic [2:0]            length_q;
  logic                  loop_q;
  logic [DATA_WIDTH-1:0] pat_q [DEPTH];
  logic [DEPTH-1:0]      pat_we;

  logic wr_en, ctrl_wr, status_wr, start_req, stop_req, busy, advance;

  // Upper write-data bits have no destination in this register map.
  logic unused_bits;
  assign unused_bits = &{1'b0, writedata[31:16]};

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en && (address == 4'd0);
  assign status_wr = wr_en && (address == 4'd3);
  assign start_req = ctrl_wr & writedata[0];
  assign stop_req  = ctrl_wr & writedata[2];
  assign busy      = (state_q != ST_IDLE);

  // Per-entry write enables for the pattern table (addresses 8..15).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pat_we
      assign pat_we[gi] = wr_en && (address == 4'(8 + gi));
    end
  endgenerate

  // Pattern table storage; cleared by reset so a fresh start replays zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (pat_we[i]) pat_q[i] <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Configuration registers PERIOD, LENGTH and the stored LOOP flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      length_q <= '0;
      loop_q   <= 1'b0;
    end else begin
      if (wr_en && address == 4'd1) period_q <= writedata[15:0];
      if (wr_en && address == 4'd2) length_q <= writedata[2:0];
      if (ctrl_wr)                  loop_q   <= writedata[1];
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: WRITE lasts one cycle, WAIT burns PERIOD cycles, then
  // advance to the next entry, wrap, or finish. STOP overrides everything.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    done_d  = done_q;
    advance = 1'b0;

    if (status_wr) done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          index_d = '0;
          done_d  = 1'b0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (period_q == 16'd0) begin
          advance = 1'b1;
        end else begin
          count_d = period_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (count_q <= 16'd1) advance = 1'b1;
        else                  count_d = count_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // index >= LENGTH also covers LENGTH being lowered mid-run.
    if (advance) begin
      if (index_q < length_q) begin
        index_d = index_q + 3'd1;
        state_d = ST_WRITE;
      end else if (loop_q) begin
        index_d = '0;
        state_d = ST_WRITE;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    // STOP leaves index and DONE as they were (apart from a STATUS clear).
    if (stop_req) begin
      state_d = ST_IDLE;
      index_d = index_q;
      done_d  = status_wr ? 1'b0 : done_q;
    end
  end

  // Master port: a single-cycle write strobe whenever the FSM is in WRITE.
  always_comb begin
    m_address    = 2'b00;
    m_chipselect = (state_q == ST_WRITE);
    m_write_n    = ~(state_q == ST_WRITE);
    m_writedata  = '0;
    if (state_q == ST_WRITE) m_writedata[DATA_WIDTH-1:0] = pat_q[index_q];
  end

  assign irq = done_q;

  // Config read mux, combinational from address.
  always_comb begin
    readdata = '0;
    case (address)
      4'd0: readdata = {29'b0, done_q, loop_q, busy};
      4'd1: readdata = {16'b0, period_q};
      4'd2: readdata = {29'b0, length_q};
      4'd3: readdata = {28'b0, done_q, index_q};
      default: begin
        if (address[3]) readdata[DATA_WIDTH-1:0] = pat_q[address[2:0]];
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Directed testbench for gpio_pattern_sequencer.
module tb_gpio_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_pattern_sequencer #(.DATA_WIDTH(12), .DEPTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .irq          (irq)
  );

  // One line per master write transaction.
  always @(posedge clk)
    if (reset_n && m_chipselect && !m_write_n)
      $display("[%0t] master write data=%h", $time, m_writedata);

  // Config write; returns 1ns after the capturing edge.
  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    $display("[%0t] cfg write addr=%0d data=%h", $time, a, d);
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    address = a; #1;
    d = readdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #12;
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", m_chipselect); end
    checks++; if (m_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b expected 1", m_write_n); end
    checks++; if (m_writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", m_writedata); end
    checks++; if (m_address !== 2'b00) begin errors++; $display("FAIL reset_maddr: got %b expected 0", m_address); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    cfg_read(4'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_control: got %h expected 0", rd); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_regmap();
    logic [31:0] rd;
    for (int a = 4; a < 8; a++) begin
      cfg_write(4'(a), 32'hFFFF_FFFF);
      cfg_read(4'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL regmap_unmapped%0d: got %h expected 0", a, rd); end
    end
    cfg_write(4'd8, 32'hFFFF_FFFF);
    cfg_read(4'd8, rd);
    checks++; if (rd !== 32'h0000_0FFF) begin errors++; $display("FAIL regmap_table0: got %h expected 00000fff", rd); end
    cfg_write(4'd15, 32'h0000_0ABC);
    cfg_read(4'd15, rd);
    checks++; if (rd !== 32'h0000_0ABC) begin errors++; $display("FAIL regmap_table7: got %h expected 00000abc", rd); end
    cfg_write(4'd1, 32'h1234_5678);
    cfg_read(4'd1, rd);
    checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL regmap_period: got %h expected 00005678", rd); end
    cfg_write(4'd2, 32'h0000_00FF);
    cfg_read(4'd2, rd);
    checks++; if (rd !== 32'h0000_0007) begin errors++; $display("FAIL regmap_length: got %h expected 7", rd); end
  endtask

  task automatic test_one_shot();
    logic [31:0] rd;
    logic        exp_cs;
    logic [31:0] exp_d;
    cfg_write(4'd8, 32'h001);
    cfg_write(4'd9, 32'h002);
    cfg_write(4'd10, 32'h004);
    cfg_write(4'd2, 32'd2);
    cfg_write(4'd1, 32'd3);
    cfg_write(4'd0, 32'h1);  // edge T
    checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 32'h001)
      begin errors++; $display("FAIL oneshot_w0: got cs=%b wn=%b d=%h expected cs=1 wn=0 d=001", m_chipselect, m_write_n, m_writedata); end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_cs = (k == 4) || (k == 8);
      exp_d  = (k == 4) ? 32'h002 : 32'h004;
      checks++; if (m_chipselect !== exp_cs) begin errors++; $display("FAIL oneshot_cs_T+%0d: got %b expected %b", k, m_chipselect, exp_cs); end
      if (exp_cs) begin
        checks++; if (m_writedata !== exp_d) begin errors++; $display("FAIL oneshot_data_T+%0d: got %h expected %h", k, m_writedata, exp_d); end
      end
      checks++; if (irq !== (k >= 12)) begin errors++; $display("FAIL oneshot_irq_T+%0d: got %b expected %b", k, irq, (k >= 12)); end
    end
    cfg_read(4'd3, rd);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL oneshot_status: got %h expected 0000000a", rd); end
    cfg_write(4'd3, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) cfg_write(4'(8 + i), 32'(i));
    cfg_write(4'd2, 32'd7);
    cfg_write(4'd1, 32'd0);
    cfg_write(4'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      checks++; if (m_chipselect !== 1'b1 || m_writedata !== 32'(k))
        begin errors++; $display("FAIL b2b_w%0d: got cs=%b d=%h expected cs=1 d=%h", k, m_chipselect, m_writedata, 32'(k)); end
    end
    step();
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL b2b_end_cs: got %b expected 0", m_chipselect); end
    cfg_read(4'd0, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL b2b_control: got %h expected 4", rd); end
  endtask

  task automatic test_loop_stop();
    logic [31:0] rd;
    logic        exp_cs;
    logic [31:0] exp_d;
    cfg_write(4'd8, 32'hAAA);
    cfg_write(4'd9, 32'h555);
    cfg_write(4'd2, 32'd1);
    cfg_write(4'd1, 32'd2);
    cfg_write(4'd0, 32'h3);  // START + LOOP
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      exp_cs = (k % 3 == 0);
      exp_d  = ((k / 3) % 2 == 1) ? 32'h555 : 32'hAAA;
      checks++; if (m_chipselect !== exp_cs) begin errors++; $display("FAIL loop_cs_T+%0d: got %b expected %b", k, m_chipselect, exp_cs); end
      if (exp_cs) begin
        checks++; if (m_writedata !== exp_d) begin errors++; $display("FAIL loop_data_T+%0d: got %h expected %h", k, m_writedata, exp_d); end
      end
    end
    cfg_write(4'd0, 32'h4);  // STOP
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL stop_cs_%0d: got %b expected 0", k, m_chipselect); end
    end
    cfg_read(4'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL stop_control: got %h expected 0", rd); end
  endtask

  task automatic test_restart_priority();
    logic [31:0] rd;
    cfg_write(4'd2, 32'd3);
    cfg_write(4'd1, 32'd5);
    cfg_write(4'd0, 32'h1);  // edge T; writes at T, T+6
    for (int k = 0; k < 7; k++) step();
    cfg_write(4'd0, 32'h1);  // edge T+8, in WAIT with index 1
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL restart_cs: got %b expected 0", m_chipselect); end
    cfg_read(4'd3, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL restart_status: got %h expected 1", rd); end
    cfg_write(4'd0, 32'h4);
    cfg_write(4'd0, 32'h5);  // START + STOP from IDLE
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL prio_cs_%0d: got %b expected 0", k, m_chipselect); end
    end
    cfg_read(4'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL prio_control: got %h expected 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    // Reset during a WRITE cycle drops the strobe without a clock edge.
    cfg_write(4'd8, 32'h123);
    cfg_write(4'd2, 32'd1);
    cfg_write(4'd1, 32'd4);
    cfg_write(4'd0, 32'h1);
    checks++; if (m_chipselect !== 1'b1) begin errors++; $display("FAIL rstw_pre_cs: got %b expected 1", m_chipselect); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'h0)
      begin errors++; $display("FAIL rstw_async: got cs=%b wn=%b d=%h expected cs=0 wn=1 d=0", m_chipselect, m_write_n, m_writedata); end
    @(negedge clk); reset_n = 1'b1;
    // Reset in the middle of WAIT.
    cfg_write(4'd8, 32'h123);
    cfg_write(4'd2, 32'd1);
    cfg_write(4'd1, 32'd4);
    cfg_write(4'd0, 32'h3);
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (m_chipselect !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL rstwait_async: got cs=%b irq=%b expected 0 0", m_chipselect, irq); end
    step();
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL rstwait_nowrite_%0d: got %b expected 0", k, m_chipselect); end
    end
    for (int a = 0; a < 16; a++) begin
      cfg_read(4'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstwait_reg%0d: got %h expected 0", a, rd); end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 4'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    test_reset();
    test_regmap();
    test_one_shot();
    test_back_to_back();
    test_loop_stop();
    test_restart_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
